posit_encoder: RTL and testbench
================================

# posit_encoder

Pipelined posit32 (es = 2) encoder for the PPU datapath: packs sign, scale and significand into a 32-bit posit with round-to-nearest-even, saturation and special values. It is the inverse of the operand decode stage, and its output feeds the result/writeback path of the ADDMUL, DIVSQRT and NONCOMP units. It has two register stages and an elastic valid/ready handshake on both sides.

## Interface

Parameters:
- `TagWidth`, default 5: width of the opaque tag carried alongside each operation.

Ports:
- `clk_i`: input, 1 bit. Single clock.
- `rst_ni`: input, 1 bit. Reset, asynchronous, active-low.
- `flush_i`: input, 1 bit. Synchronous kill of all in-flight entries.
- `in_valid_i`: input, 1 bit. Input operation valid.
- `in_ready_o`: output, 1 bit. Encoder can accept an input this cycle.
- `sign_i`: input, 1 bit. Result sign (1 = negative).
- `is_zero_i`: input, 1 bit. Result is exactly zero.
- `is_nar_i`: input, 1 bit. Result is NaR.
- `scale_i`: input, 10 bits, signed two's complement. Total exponent: 4·k + e.
- `mant_i`: input, 28 bits. Fraction bits below the hidden 1, MSB first.
- `sticky_i`: input, 1 bit. OR of all discarded lower bits from upstream.
- `tag_i`: input, `TagWidth` bits. Passthrough tag.
- `out_valid_o`: output, 1 bit. Result valid.
- `out_ready_i`: input, 1 bit. Consumer accepts the result.
- `result_o`: output, 32 bits. Encoded posit.
- `status_o`: output, 5 bits. Status flags {NV, DZ, OF, UF, NX}.
- `tag_o`: output, `TagWidth` bits. Tag of the result.

## Operation

Stage 1 (decompose), registered:
- Clamp `scale_i` to [-120, 120].
  - Clamping from above sets OF.
  - Clamping from below sets UF.
- Compute k = clamped scale >>> 2 (arithmetic shift, floor) and e = clamped scale[1:0].
- Regime:
  - k ≥ 0: (k+1) ones, then a 0. Length k+2.
  - k < 0: (−k) zeros, then a 1. Length −k+1.
- Form a 63-bit string: regime, e (2 bits), `mant_i`, zero padding.
  - Kept body = top 31 bits.
  - Round bit = next bit.
  - Sticky = OR of the remaining bits OR `sticky_i`.
- Register for stage 2: body, round bit, sticky, sign, special flags, OF, UF, tag.

Stage 2 (round/pack), registered:
- Round up when round & (sticky | body[0]); this is RNE on the bit pattern.
- Increment carry out of 31 bits → body = 0x7FFFFFFF (maxpos).
- Rounded body = 0 → body = 1 (minpos). A nonzero value never rounds to zero.
- result = sign ? −{0, body} (32-bit two's complement) : {0, body}.
- NX = round | sticky.
- Special values override the computed result:
  - `is_nar_i` → 0x8000_0000, status all 0.
  - Otherwise `is_zero_i` → 0x0000_0000, status all 0.
  - `is_nar_i` has priority over `is_zero_i`.
- NV and DZ are always 0 from this block; upstream ORs in its own flags.
- OF or UF also forces NX = 1.

Handshake:
- A transfer occurs on valid & ready.
- Each stage holds its payload stable until it advances.
- Stage-2 may load when it is empty or `out_ready_i` is high.
- `in_ready_o` = !s1_valid | s2_can_load. This is combinational from `out_ready_i`; there is no combinational path from `in_valid_i`.
- Full throughput: one result per cycle when `out_ready_i` is held high.

## Timing

- Reset values:
  - `out_valid_o` = 0 and both internal valid bits = 0.
  - `result_o` = 0, `status_o` = 0, `tag_o` = 0.
  - `in_ready_o` = 1 after reset.
- Latency: an input accepted in cycle N appears on `out_valid_o` in cycle N+2 when there is no stall.
- Back-pressure:
  - When `out_ready_i` = 0, stage 2 holds.
  - Stage 1 holds if stage 2 is full.
  - `in_ready_o` drops once both stages are full.
  - At most 2 entries are in flight; none is dropped or duplicated.
- Simultaneous output accept and input accept in the same cycle: the pipeline shifts and stays full.
- `flush_i`: both valid bits are cleared at the next edge. Any input accepted in that same cycle is discarded. `flush_i` has priority over the handshake.
- Reset mid-operation: all entries are lost and outputs return to reset values immediately (asynchronous).
- Payload registers update only on advance; data registers are not reset-dependent except the outputs listed above.

## Test plan

- Exact values, no stall:
  - scale 0, mant 0, sign 0 → 0x40000000, status 0, valid exactly 2 cycles after accept.
  - sign 1 → 0xC0000000.
- Rounding at scale 0:
  - mant 0x0000001 → 0x40000000 with NX = 1 (tie to even).
  - mant 0x0000003 → 0x40000002 with NX = 1.
  - mant 0x0000001 with `sticky_i` = 1 → 0x40000001.
- Saturation:
  - scale 120 → 0x7FFFFFFF, status 0.
  - scale 200 → 0x7FFFFFFF with OF = 1, NX = 1.
  - scale −120 → 0x00000001.
  - scale −300, sign 1 → 0xFFFFFFFF with UF = 1, NX = 1.
- Specials:
  - `is_nar_i` = 1 with `is_zero_i` = 1 → 0x80000000.
  - `is_zero_i` alone → 0x00000000; status 0 in both cases.
- Back-pressure: stream 6 tagged ops while toggling `out_ready_i` randomly → all 6 tags are delivered in order, with no duplicates, and `in_ready_o` = 0 whenever 2 entries are held.
- Flush and reset:
  - Assert `flush_i` with 2 entries in flight → `out_valid_o` = 0 next cycle and no stale output afterwards.
  - Pulse `rst_ni` low mid-stream → outputs are immediately at reset values and `in_ready_o` = 1 after release.

Source files
------------

// File: rtl/posit_encoder.sv
// posit_encoder
//
// Two-stage pipelined posit32 (es = 2) encoder. It packs a sign, a signed
// scale (4*k + e) and a 28-bit fraction into a 32-bit posit using
// round-to-nearest-even, saturation to maxpos/minpos and the special values
// zero and NaR. Both sides use an elastic valid/ready handshake.
//
// Stage 1 clamps the scale, builds the regime/exponent/fraction bit string
// and splits it into a 31-bit body, a round bit and a sticky bit.
// Stage 2 rounds, saturates, applies the sign and overrides for specials.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous kill of all in-flight entries
//   in_valid_i/in_ready_o  input handshake
//   sign_i, is_zero_i, is_nar_i, scale_i, mant_i, sticky_i, tag_i
//                          operation payload
//   out_valid_o/out_ready_i output handshake
//   result_o               encoded posit
//   status_o               {NV, DZ, OF, UF, NX}
//   tag_o                  tag travelling with the result
module posit_encoder #(
    parameter int TagWidth = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                sign_i,
    input  logic                is_zero_i,
    input  logic                is_nar_i,
    input  logic signed [9:0]   scale_i,
    input  logic [27:0]         mant_i,
    input  logic                sticky_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         result_o,
    output logic [4:0]          status_o,
    output logic [TagWidth-1:0] tag_o
);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_valid_r;
    logic s2_can_load_s;
    logic s1_advance_s;
    logic in_fire_s;

    assign s2_can_load_s = !out_valid_o || out_ready_i;
    assign s1_advance_s  = s1_valid_r && s2_can_load_s;
    assign in_ready_o    = !s1_valid_r || s2_can_load_s;
    assign in_fire_s     = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Stage 1: decompose
    // ------------------------------------------------------------------
    // After clamping to [-120, 120] the scale fits in 8 signed bits, so
    // k = scale >>> 2 is simply the top six bits and e the bottom two.
    logic [7:0]  scale_clamped_s;
    logic        of_s;
    logic        uf_s;
    logic [5:0]  k_s;
    logic [1:0]  e_s;
    logic [5:0]  run_s;
    logic [5:0]  regime_len_s;
    logic [62:0] regime_word_s;
    logic [62:0] tail_s;
    logic [62:0] str_s;
    logic [30:0] body_s;
    logic        round_s;
    logic        sticky_s;

    // Scale saturation with overflow/underflow flags
    always_comb begin
        scale_clamped_s = scale_i[7:0];
        of_s            = 1'b0;
        uf_s            = 1'b0;
        if (scale_i > 10'sd120) begin
            scale_clamped_s = 8'h78;
            of_s            = 1'b1;
        end else if (scale_i < -10'sd120) begin
            scale_clamped_s = 8'h88;
            uf_s            = 1'b1;
        end else begin
            scale_clamped_s = scale_i[7:0];
        end
    end

    assign k_s = scale_clamped_s[7:2];
    assign e_s = scale_clamped_s[1:0];

    // Regime construction and assembly of the 63-bit posit string
    always_comb begin
        run_s         = 6'd0;
        regime_len_s  = 6'd0;
        regime_word_s = 63'd0;
        if (k_s[5]) begin
            // k < 0: (-k) zeros terminated by a single one
            run_s         = 6'd0 - k_s;
            regime_word_s = {1'b1, 62'd0} >> run_s;
            regime_len_s  = run_s + 6'd1;
        end else begin
            // k >= 0: (k+1) ones terminated by a zero
            run_s         = k_s + 6'd1;
            regime_word_s = ~({63{1'b1}} >> run_s);
            regime_len_s  = k_s + 6'd2;
        end
        tail_s   = {e_s, mant_i, 33'd0} >> regime_len_s;
        str_s    = regime_word_s | tail_s;
        body_s   = str_s[62:32];
        round_s  = str_s[31];
        sticky_s = (|str_s[30:0]) | sticky_i;
    end

    logic [30:0]         s1_body_r;
    logic                s1_round_r;
    logic                s1_sticky_r;
    logic                s1_sign_r;
    logic                s1_zero_r;
    logic                s1_nar_r;
    logic                s1_of_r;
    logic                s1_uf_r;
    logic [TagWidth-1:0] s1_tag_r;

    // Stage-1 payload capture on input transfer
    always_ff @(posedge clk_i) begin
        if (in_fire_s) begin
            s1_body_r   <= body_s;
            s1_round_r  <= round_s;
            s1_sticky_r <= sticky_s;
            s1_sign_r   <= sign_i;
            s1_zero_r   <= is_zero_i;
            s1_nar_r    <= is_nar_i;
            s1_of_r     <= of_s;
            s1_uf_r     <= uf_s;
            s1_tag_r    <= tag_i;
        end else begin
            s1_body_r   <= s1_body_r;
            s1_round_r  <= s1_round_r;
            s1_sticky_r <= s1_sticky_r;
            s1_sign_r   <= s1_sign_r;
            s1_zero_r   <= s1_zero_r;
            s1_nar_r    <= s1_nar_r;
            s1_of_r     <= s1_of_r;
            s1_uf_r     <= s1_uf_r;
            s1_tag_r    <= s1_tag_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack
    // ------------------------------------------------------------------
    logic        round_up_s;
    logic [31:0] sum_s;
    logic [30:0] body_rnd_s;
    logic [31:0] mag_s;
    logic [31:0] result_s;
    logic [4:0]  status_s;
    logic        nx_s;

    // Rounding (RNE on the bit pattern), saturation, sign and specials
    always_comb begin
        round_up_s = s1_round_r & (s1_sticky_r | s1_body_r[0]);
        sum_s      = {1'b0, s1_body_r} + {31'd0, round_up_s};
        if (sum_s[31]) begin
            body_rnd_s = 31'h7FFF_FFFF;
        end else if (sum_s[30:0] == 31'd0) begin
            // a nonzero value never rounds to zero
            body_rnd_s = 31'd1;
        end else begin
            body_rnd_s = sum_s[30:0];
        end
        mag_s = {1'b0, body_rnd_s};
        nx_s  = s1_round_r | s1_sticky_r | s1_of_r | s1_uf_r;
        if (s1_nar_r) begin
            result_s = 32'h8000_0000;
            status_s = 5'd0;
        end else if (s1_zero_r) begin
            result_s = 32'h0000_0000;
            status_s = 5'd0;
        end else begin
            result_s = s1_sign_r ? (32'd0 - mag_s) : mag_s;
            status_s = {1'b0, 1'b0, s1_of_r, s1_uf_r, nx_s};
        end
    end

    // Valid bits: flush wins over every handshake event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r  <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            s1_valid_r  <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (in_fire_s) begin
                s1_valid_r <= 1'b1;
            end else if (s1_advance_s) begin
                s1_valid_r <= 1'b0;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (s1_advance_s) begin
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end else begin
                out_valid_o <= out_valid_o;
            end
        end
    end

    // Output payload registers, loaded when stage 1 advances
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= 32'd0;
            status_o <= 5'd0;
            tag_o    <= '0;
        end else if (s1_advance_s) begin
            result_o <= result_s;
            status_o <= status_s;
            tag_o    <= s1_tag_r;
        end else begin
            result_o <= result_o;
            status_o <= status_o;
            tag_o    <= tag_o;
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: the driver issues directed vectors
// with hand-computed results; a negedge monitor pushes the expected entry
// on each input transfer and pops/compares on each output transfer.
module tb_posit_encoder;
    localparam int TW = 5;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic                 sign_i = 1'b0;
    logic                 is_zero_i = 1'b0;
    logic                 is_nar_i = 1'b0;
    logic signed [9:0]    scale_i = 10'sd0;
    logic [27:0]          mant_i = 28'd0;
    logic                 sticky_i = 1'b0;
    logic [TW-1:0]        tag_i = '0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic [31:0]          result_o;
    logic [4:0]           status_o;
    logic [TW-1:0]        tag_o;

    posit_encoder #(.TagWidth(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sign_i(sign_i), .is_zero_i(is_zero_i), .is_nar_i(is_nar_i),
        .scale_i(scale_i), .mant_i(mant_i), .sticky_i(sticky_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .tag_o(tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]   res;
        logic [4:0]    st;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    exp_t          push_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            delivered = 0;
    logic [31:0]   exp_res = 32'd0;
    logic [4:0]    exp_st = 5'd0;
    bit            exp_lat = 1'b0;
    bit            rnd_rdy = 1'b0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("in_ready", {31'd0, in_ready_o},
                  {31'd0, (sb_q.size() < 2) || out_ready_i});
            if (out_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_output: got valid result %h expected no output", result_o);
                end else if (out_ready_i) begin
                    mon_e = sb_q.pop_front();
                    delivered++;
                    check("result", result_o, mon_e.res);
                    check("status", {27'd0, status_o}, {27'd0, mon_e.st});
                    check("tag", {27'd0, tag_o}, {27'd0, mon_e.tag});
                    if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc), 32'd2);
                end
            end
            if (flush_i) begin
                sb_q.delete();
            end else if (in_valid_i && in_ready_o) begin
                push_e.res = exp_res;
                push_e.st  = exp_st;
                push_e.tag = tag_i;
                push_e.acc = cyc;
                push_e.lat = exp_lat;
                sb_q.push_back(push_e);
            end
        end
    end

    task automatic send(input logic s, input logic signed [9:0] sc, input logic [27:0] m,
                        input logic stk, input logic z, input logic n, input logic [TW-1:0] tg,
                        input logic [31:0] er, input logic [4:0] es, input bit lat);
        bit accepted = 1'b0;
        sign_i = s; scale_i = sc; mant_i = m; sticky_i = stk;
        is_zero_i = z; is_nar_i = n; tag_i = tg;
        exp_res = er; exp_st = es; exp_lat = lat;
        in_valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            accepted = in_ready_o;
            @(posedge clk_i);
            #1;
            if (accepted) break;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept for tag %0d expected accept", tg);
        end
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            if (rnd_rdy && i < 10) out_ready_i = 1'($urandom_range(0, 1));
            else out_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    logic [31:0] bp_exp [6] = '{32'h4000_0000, 32'h6000_0000, 32'h7000_0000,
                                32'h7800_0000, 32'h7C00_0000, 32'h7E00_0000};
    int del_before;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_status", {27'd0, status_o}, 32'd0);
        check("rst_tag", {27'd0, tag_o}, 32'd0);
        rst_ni = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;

        // Exact values and latency
        send(1'b0, 10'sd0, 28'h0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h4000_0000, 5'b00000, 1'b1);
        drain();
        send(1'b1, 10'sd0, 28'h0, 1'b0, 1'b0, 1'b0, 5'd2, 32'hC000_0000, 5'b00000, 1'b1);
        // Rounding at scale 0
        send(1'b0, 10'sd0, 28'h1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h4000_0000, 5'b00001, 1'b0);
        send(1'b0, 10'sd0, 28'h3, 1'b0, 1'b0, 1'b0, 5'd4, 32'h4000_0002, 5'b00001, 1'b0);
        send(1'b0, 10'sd0, 28'h1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h4000_0001, 5'b00001, 1'b0);
        // Regime / exponent patterns
        send(1'b0, 10'sd1, 28'h0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h4800_0000, 5'b00000, 1'b0);
        send(1'b0, -10'sd1, 28'h0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h3800_0000, 5'b00000, 1'b0);
        send(1'b1, 10'sd1, 28'h0, 1'b0, 1'b0, 1'b0, 5'd8, 32'hB800_0000, 5'b00000, 1'b0);
        // Saturation
        send(1'b0, 10'sd120, 28'h0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h7FFF_FFFF, 5'b00000, 1'b0);
        send(1'b0, 10'sd200, 28'h0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h7FFF_FFFF, 5'b00101, 1'b0);
        send(1'b0, -10'sd120, 28'h0, 1'b0, 1'b0, 1'b0, 5'd11, 32'h0000_0001, 5'b00000, 1'b0);
        send(1'b1, -10'sd300, 28'h0, 1'b0, 1'b0, 1'b0, 5'd12, 32'hFFFF_FFFF, 5'b00011, 1'b0);
        // Specials
        send(1'b0, 10'sd200, 28'h5, 1'b1, 1'b1, 1'b1, 5'd13, 32'h8000_0000, 5'b00000, 1'b0);
        send(1'b1, 10'sd3, 28'h7, 1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_0000, 5'b00000, 1'b0);
        drain();

        // Back-pressure: six tagged ops with random out_ready
        del_before = delivered;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 6; i++)
            send(1'b0, 10'(i * 4), 28'h0, 1'b0, 1'b0, 1'b0, 5'(16 + i), bp_exp[i], 5'b00000, 1'b0);
        drain();
        rnd_rdy = 1'b0;
        out_ready_i = 1'b1;
        check("bp_delivered", 32'(delivered - del_before), 32'd6);

        // Flush with two entries in flight
        out_ready_i = 1'b0;
        send(1'b0, 10'sd4, 28'h0, 1'b0, 1'b0, 1'b0, 5'd24, 32'h6000_0000, 5'b00000, 1'b0);
        send(1'b0, 10'sd8, 28'h0, 1'b0, 1'b0, 1'b0, 5'd25, 32'h7000_0000, 5'b00000, 1'b0);
        @(negedge clk_i);
        check("full_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check("flush_valid", {31'd0, out_valid_o}, 32'd0);
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        send(1'b0, 10'sd0, 28'h0, 1'b0, 1'b0, 1'b0, 5'd26, 32'h4000_0000, 5'b00000, 1'b1);
        drain();

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        send(1'b0, 10'sd4, 28'h0, 1'b0, 1'b0, 1'b0, 5'd27, 32'h6000_0000, 5'b00000, 1'b0);
        send(1'b1, 10'sd4, 28'h0, 1'b0, 1'b0, 1'b0, 5'd28, 32'hA000_0000, 5'b00000, 1'b0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_status", {27'd0, status_o}, 32'd0);
        check("mid_rst_tag", {27'd0, tag_o}, 32'd0);
        sb_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        send(1'b1, 10'sd4, 28'h0, 1'b0, 1'b0, 1'b0, 5'd29, 32'hA000_0000, 5'b00000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
